// File: rtl/msf_pkg.sv
// MSF time-code transmitter: shared constants and types.
// Frame layout, field positions and the on-air keying rule.
package msf_pkg;

  localparam logic [3:0] SLOTS_PER_SEC = 4'd10;
  localparam logic [5:0] SECS_PER_MIN  = 6'd60;

  localparam logic [5:0] YEAR_SEC   = 6'd17;
  localparam logic [5:0] MONTH_SEC  = 6'd25;
  localparam logic [5:0] DAY_SEC    = 6'd30;
  localparam logic [5:0] DOW_SEC    = 6'd36;
  localparam logic [5:0] HOUR_SEC   = 6'd39;
  localparam logic [5:0] MINUTE_SEC = 6'd45;
  localparam logic [5:0] MARKER_SEC = 6'd52;

  localparam logic [5:0] BST_WARN_SEC = 6'd53;
  localparam logic [5:0] PAR_YEAR_SEC = 6'd54;
  localparam logic [5:0] PAR_DATE_SEC = 6'd55;
  localparam logic [5:0] PAR_DOW_SEC  = 6'd56;
  localparam logic [5:0] PAR_TIME_SEC = 6'd57;
  localparam logic [5:0] BST_SEC      = 6'd58;

  localparam logic [7:0] MARKER = 8'b01111110;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef struct packed {
    logic [3:0] year_h;
    logic [3:0] year_l;
    logic       month_h;
    logic [3:0] month_l;
    logic [1:0] day_h;
    logic [3:0] day_l;
    logic [2:0] dow;
    logic [1:0] hour_h;
    logic [3:0] hour_l;
    logic [2:0] minute_h;
    logic [3:0] minute_l;
    logic       bst;
    logic       bst_warn;
  } msf_fields_t;

  // Carrier level for one 100 ms slot; A/B are sent as carrier-off.
  function automatic logic carrier_level(
    input logic [5:0] sec,
    input logic [3:0] slot,
    input logic       a,
    input logic       b
  );
    logic lvl;
    lvl = 1'b1;
    if (sec == 6'd0) begin
      lvl = (slot >= 4'd5);
    end else if (slot == 4'd0) begin
      lvl = 1'b0;
    end else if (slot == 4'd1) begin
      lvl = ~a;
    end else if (slot == 4'd2) begin
      lvl = ~b;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/msf_ab_lookup.sv
// MSF A/B bit lookup for one second of the frame.
// Pure combinational; includes the four odd-parity bits.
module msf_ab_lookup
  import msf_pkg::*;
(
  input  logic [5:0]  sec,
  input  msf_fields_t fields,
  output logic        a,
  output logic        b
);

  logic [42:0] bits;
  logic [5:0]  idx;

  // A17..A59 packed MSB first, so A[n] sits at bits[59-n].
  assign bits = {
    fields.year_h, fields.year_l,
    fields.month_h, fields.month_l,
    fields.day_h, fields.day_l,
    fields.dow,
    fields.hour_h, fields.hour_l,
    fields.minute_h, fields.minute_l,
    MARKER
  };

  assign idx = SECS_PER_MIN - 6'd1 - sec;

  // A bit: zero for the unused DUT1 seconds.
  always_comb begin
    a = 1'b0;
    if (sec >= YEAR_SEC && sec < SECS_PER_MIN) begin
      a = bits[idx];
    end
  end

  // B bit: flags and odd parity over the covered A fields.
  always_comb begin
    b = 1'b0;
    case (sec)
      BST_WARN_SEC: b = fields.bst_warn;
      PAR_YEAR_SEC: b = ~^{fields.year_h, fields.year_l};
      PAR_DATE_SEC: b = ~^{fields.month_h, fields.month_l,
                           fields.day_h, fields.day_l};
      PAR_DOW_SEC:  b = ~^fields.dow;
      PAR_TIME_SEC: b = ~^{fields.hour_h, fields.hour_l,
                           fields.minute_h, fields.minute_l};
      BST_SEC:      b = fields.bst;
      default:      b = 1'b0;
    endcase
  end

endmodule

// File: rtl/msf_encoder.sv
// MSF time-code transmitter: frame timing and carrier keying.
// Counters run prescaler -> slot -> second; data latched per frame.
module msf_encoder
  import msf_pkg::*;
#(
  parameter int unsigned DIV = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [3:0] year_h_i,
  input  logic [3:0] year_l_i,
  input  logic       month_h_i,
  input  logic [3:0] month_l_i,
  input  logic [1:0] day_h_i,
  input  logic [3:0] day_l_i,
  input  logic [2:0] dow_i,
  input  logic [1:0] hour_h_i,
  input  logic [3:0] hour_l_i,
  input  logic [2:0] minute_h_i,
  input  logic [3:0] minute_l_i,
  input  logic       bst_i,
  input  logic       bst_warn_i,
  output logic       carrier_o,
  output logic       sec_o,
  output logic       min_o,
  output logic       busy_o
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      slot_q, slot_d;
  logic [5:0]      sec_q, sec_d;
  logic            carrier_q, carrier_d;
  logic            sec_strb_q, sec_strb_d;
  logic            min_strb_q, min_strb_d;
  logic            load;
  logic            presc_wrap, slot_wrap, frame_end;
  logic            a_bit, b_bit;
  msf_fields_t     fields_q, fields_in;

  assign fields_in = '{
    year_h:   year_h_i,
    year_l:   year_l_i,
    month_h:  month_h_i,
    month_l:  month_l_i,
    day_h:    day_h_i,
    day_l:    day_l_i,
    dow:      dow_i,
    hour_h:   hour_h_i,
    hour_l:   hour_l_i,
    minute_h: minute_h_i,
    minute_l: minute_l_i,
    bst:      bst_i,
    bst_warn: bst_warn_i
  };

  assign presc_wrap = (presc_q == PRESC_MAX);
  assign slot_wrap  = presc_wrap &&
                      (slot_q == SLOTS_PER_SEC - 4'd1);
  assign frame_end  = slot_wrap &&
                      (sec_q == SECS_PER_MIN - 6'd1);

  // Next-state, counter advance and strobe generation.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    slot_d     = slot_q;
    sec_d      = sec_q;
    sec_strb_d = 1'b0;
    min_strb_d = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d    = RUN;
          presc_d    = '0;
          slot_d     = '0;
          sec_d      = '0;
          sec_strb_d = 1'b1;
          min_strb_d = 1'b1;
          load       = 1'b1;
        end
      end
      RUN: begin
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        if (presc_wrap) begin
          slot_d = slot_wrap ? 4'd0 : slot_q + 4'd1;
        end
        if (slot_wrap) begin
          sec_d      = frame_end ? 6'd0 : sec_q + 6'd1;
          sec_strb_d = 1'b1;
        end
        if (frame_end) begin
          if (en_i) begin
            min_strb_d = 1'b1;
            load       = 1'b1;
          end else begin
            state_d    = IDLE;
            sec_strb_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bits for the second about to be entered; second 0 needs no data.
  msf_ab_lookup u_lookup (
    .sec    (sec_d),
    .fields (fields_q),
    .a      (a_bit),
    .b      (b_bit)
  );

  assign carrier_d = (state_d == RUN) ?
    carrier_level(sec_d, slot_d, a_bit, b_bit) : 1'b1;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, registered outputs and per-frame data latch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q    <= '0;
      slot_q     <= '0;
      sec_q      <= '0;
      carrier_q  <= 1'b1;
      sec_strb_q <= 1'b0;
      min_strb_q <= 1'b0;
      fields_q   <= '0;
    end else begin
      presc_q    <= presc_d;
      slot_q     <= slot_d;
      sec_q      <= sec_d;
      carrier_q  <= carrier_d;
      sec_strb_q <= sec_strb_d;
      min_strb_q <= min_strb_d;
      if (load) begin
        fields_q <= fields_in;
      end
    end
  end

  assign carrier_o = carrier_q;
  assign sec_o     = sec_strb_q;
  assign min_o     = min_strb_q;
  assign busy_o    = (state_q == RUN);

endmodule
